// File: rtl/pipe_ctrl_hazard_if.sv
// Control/hazard bundle between the decode side of the core and the hazard unit.
// The core side is the master: it drives the D bundle and PCSrcE and consumes the staged controls.
interface pipe_ctrl_hazard_if #(
  parameter int CNT_W = 16
) ();
  logic             RegWriteD;
  logic             ALUSrcD;
  logic             MemWriteD;
  logic             ResultSrcD;
  logic             BranchD;
  logic [2:0]       ALUControlD;
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       RdD;
  logic             PCSrcE;

  logic             RegWriteE;
  logic             ALUSrcE;
  logic             MemWriteE;
  logic             ResultSrcE;
  logic             BranchE;
  logic [2:0]       ALUControlE;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic             RegWriteM;
  logic             MemWriteM;
  logic             ResultSrcM;
  logic [4:0]       RdM;
  logic             RegWriteW;
  logic             ResultSrcW;
  logic [4:0]       RdW;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD, ALUControlD,
           Rs1D, Rs2D, RdD, PCSrcE,
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           Rs1E, Rs2E, RdE, RegWriteM, MemWriteM, ResultSrcM, RdM,
           RegWriteW, ResultSrcW, RdW, StallF, StallD, FlushD, FlushE,
           ForwardAE, ForwardBE, stall_cnt, flush_cnt
  );

  modport slave (
    input  RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD, ALUControlD,
           Rs1D, Rs2D, RdD, PCSrcE,
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           Rs1E, Rs2E, RdE, RegWriteM, MemWriteM, ResultSrcM, RdM,
           RegWriteW, ResultSrcW, RdW, StallF, StallD, FlushD, FlushE,
           ForwardAE, ForwardBE, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_hazard_unit.sv
// Stages the decoded control bundle through E/M/W, resolves load-use and branch hazards,
// selects EX forwarding sources and counts stall/flush events (saturating).
module pipe_ctrl_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_ctrl_hazard_if.slave  bus
);
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic [2:0] alu_control;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } e_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       result_src;
    logic [4:0] rd;
  } m_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       result_src;
    logic [4:0] rd;
  } w_ctrl_t;

  e_ctrl_t          e_q, e_d;
  m_ctrl_t          m_q, m_d;
  w_ctrl_t          w_q, w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lw_stall;
  logic             stall;
  logic             flush_e;

  // Operand source for one EX register index; the younger M result wins over W, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input m_ctrl_t m, input w_ctrl_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (m.reg_write && (m.rd != 5'd0) && (m.rd == rs)) begin
      sel = 2'b10;
    end else if (w.reg_write && (w.rd != 5'd0) && (w.rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    lw_stall = e_q.result_src && (e_q.rd != 5'd0) &&
               ((e_q.rd == bus.Rs1D) || (e_q.rd == bus.Rs2D));
    // A taken branch means D is on the wrong path, so it is flushed rather than held.
    stall    = lw_stall && !bus.PCSrcE;
    flush_e  = lw_stall || bus.PCSrcE;
  end

  always_comb begin
    e_d = '0;
    if (!flush_e) begin
      e_d.reg_write   = bus.RegWriteD;
      e_d.alu_src     = bus.ALUSrcD;
      e_d.mem_write   = bus.MemWriteD;
      e_d.result_src  = bus.ResultSrcD;
      e_d.branch      = bus.BranchD;
      e_d.alu_control = bus.ALUControlD;
      e_d.rs1         = bus.Rs1D;
      e_d.rs2         = bus.Rs2D;
      e_d.rd          = bus.RdD;
    end

    m_d.reg_write  = e_q.reg_write;
    m_d.mem_write  = e_q.mem_write;
    m_d.result_src = e_q.result_src;
    m_d.rd         = e_q.rd;

    w_d.reg_write  = m_q.reg_write;
    w_d.result_src = m_q.result_src;
    w_d.rd         = m_q.rd;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (bus.PCSrcE && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.RegWriteE   = e_q.reg_write;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.MemWriteE   = e_q.mem_write;
  assign bus.ResultSrcE  = e_q.result_src;
  assign bus.BranchE     = e_q.branch;
  assign bus.ALUControlE = e_q.alu_control;
  assign bus.Rs1E        = e_q.rs1;
  assign bus.Rs2E        = e_q.rs2;
  assign bus.RdE         = e_q.rd;
  assign bus.RegWriteM   = m_q.reg_write;
  assign bus.MemWriteM   = m_q.mem_write;
  assign bus.ResultSrcM  = m_q.result_src;
  assign bus.RdM         = m_q.rd;
  assign bus.RegWriteW   = w_q.reg_write;
  assign bus.ResultSrcW  = w_q.result_src;
  assign bus.RdW         = w_q.rd;
  assign bus.StallF      = stall;
  assign bus.StallD      = stall;
  assign bus.FlushD      = bus.PCSrcE;
  assign bus.FlushE      = flush_e;
  assign bus.ForwardAE   = fwd_sel(e_q.rs1, m_q, w_q);
  assign bus.ForwardBE   = fwd_sel(e_q.rs2, m_q, w_q);
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl_hazard_unit.sv
// Directed bench: stimulus queues expected values tagged with the sample cycle,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_pipe_ctrl_hazard_unit;
  localparam int CNT_W = 4;

  localparam int F_RWE = 0, F_ALUCE = 1, F_RDE = 2, F_RWM = 3, F_RDM = 4, F_RWW = 5,
                 F_RDW = 6, F_STF = 7, F_STD = 8, F_FLD = 9, F_FLE = 10, F_FWA = 11,
                 F_FWB = 12, F_SCNT = 13, F_FCNT = 14, F_MWE = 15, F_RSE = 16, F_RS1E = 17;

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   ncount;
  int   checks;
  int   errors;

  pipe_ctrl_hazard_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl_hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] get_field(input int f);
    case (f)
      F_RWE:   return 32'(bus.RegWriteE);
      F_ALUCE: return 32'(bus.ALUControlE);
      F_RDE:   return 32'(bus.RdE);
      F_RWM:   return 32'(bus.RegWriteM);
      F_RDM:   return 32'(bus.RdM);
      F_RWW:   return 32'(bus.RegWriteW);
      F_RDW:   return 32'(bus.RdW);
      F_STF:   return 32'(bus.StallF);
      F_STD:   return 32'(bus.StallD);
      F_FLD:   return 32'(bus.FlushD);
      F_FLE:   return 32'(bus.FlushE);
      F_FWA:   return 32'(bus.ForwardAE);
      F_FWB:   return 32'(bus.ForwardBE);
      F_SCNT:  return 32'(bus.stall_cnt);
      F_FCNT:  return 32'(bus.flush_cnt);
      F_MWE:   return 32'(bus.MemWriteE);
      F_RSE:   return 32'(bus.ResultSrcE);
      F_RS1E:  return 32'(bus.Rs1E);
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: every negedge compares all expectations due at this cycle.
  initial begin
    ncount = 0;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk);
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == ncount) begin
          logic [31:0] got;
          got = get_field(exp_q[i].fld);
          checks++;
          if (got !== exp_q[i].val) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", exp_q[i].name, ncount, got, exp_q[i].val);
          end else begin
            $display("[cyc %0d] %s ok (%0d)", ncount, exp_q[i].name, got);
          end
          exp_q.delete(i);
        end
      end
      ncount++;
    end
  end

  task automatic push_exp(input int dly, input int fld, input int val, input string name);
    exp_t e;
    e.cyc  = ncount + dly;
    e.fld  = fld;
    e.val  = 32'(val);
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic rw, input logic mw, input logic rs, input logic [2:0] aluc,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    bus.RegWriteD   = rw;
    bus.ALUSrcD     = 1'b0;
    bus.MemWriteD   = mw;
    bus.ResultSrcD  = rs;
    bus.BranchD     = 1'b0;
    bus.ALUControlD = aluc;
    bus.Rs1D        = rs1;
    bus.Rs2D        = rs2;
    bus.RdD         = rd;
  endtask

  task automatic nop_d();
    drive_d(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic drain(input int n);
    nop_d();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst        = 1'b0;
    bus.PCSrcE = 1'b0;
    nop_d();
    tick();

    // Reset: outputs zero regardless of D inputs.
    drive_d(1'b1, 1'b0, 1'b1, 3'b010, 5'd5, 5'd5, 5'd5);
    push_exp(0, F_RWE,  0, "rst_RegWriteE");
    push_exp(0, F_RWW,  0, "rst_RegWriteW");
    push_exp(0, F_STF,  0, "rst_StallF");
    push_exp(0, F_FLE,  0, "rst_FlushE");
    push_exp(0, F_SCNT, 0, "rst_stall_cnt");
    tick();
    rst = 1'b1;

    // Latency through E/M/W.
    drive_d(1'b1, 1'b0, 1'b0, 3'b010, 5'd0, 5'd0, 5'd5);
    push_exp(0, F_RWE,   0, "lat_RegWriteE_pre");
    push_exp(1, F_RWE,   1, "lat_RegWriteE");
    push_exp(1, F_ALUCE, 2, "lat_ALUControlE");
    push_exp(1, F_RDE,   5, "lat_RdE");
    push_exp(2, F_RWM,   1, "lat_RegWriteM");
    push_exp(2, F_RDM,   5, "lat_RdM");
    push_exp(3, F_RWW,   1, "lat_RegWriteW");
    push_exp(3, F_RDW,   5, "lat_RdW");
    push_exp(4, F_RWW,   0, "lat_RegWriteW_after");
    tick();
    drain(4);

    // Load-use: one bubble, then W forwarding.
    drive_d(1'b1, 1'b0, 1'b1, 3'd0, 5'd0, 5'd0, 5'd5);
    tick();
    drive_d(1'b1, 1'b0, 1'b0, 3'd0, 5'd5, 5'd6, 5'd8);
    push_exp(0, F_STF, 1, "lu_StallF");
    push_exp(0, F_STD, 1, "lu_StallD");
    push_exp(0, F_FLE, 1, "lu_FlushE");
    push_exp(0, F_FLD, 0, "lu_FlushD");
    tick();
    push_exp(0, F_STF,  0, "lu_StallF_once");
    push_exp(0, F_FLE,  0, "lu_FlushE_once");
    push_exp(0, F_RWE,  0, "lu_bubble_RegWriteE");
    push_exp(0, F_SCNT, 1, "lu_stall_cnt");
    tick();
    nop_d();
    push_exp(0, F_RS1E, 5, "lu_Rs1E");
    push_exp(0, F_FWA,  1, "lu_ForwardAE_W");
    push_exp(0, F_FWB,  0, "lu_ForwardBE");
    tick();
    push_exp(0, F_FWA,  0, "lu_ForwardAE_done");
    drain(3);

    // Forwarding: M beats W on the same register.
    drive_d(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd7);
    tick();
    tick();
    drive_d(1'b0, 1'b0, 1'b0, 3'd0, 5'd7, 5'd7, 5'd0);
    tick();
    nop_d();
    push_exp(0, F_FWA, 2, "fw_prio_A");
    push_exp(0, F_FWB, 2, "fw_prio_B");
    drain(3);

    // Forwarding: W for A, M for B.
    drive_d(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd7);
    tick();
    drive_d(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd3);
    tick();
    drive_d(1'b0, 1'b0, 1'b0, 3'd0, 5'd7, 5'd3, 5'd0);
    tick();
    nop_d();
    push_exp(0, F_FWA, 1, "fw_mix_A");
    push_exp(0, F_FWB, 2, "fw_mix_B");
    drain(3);

    // Forwarding: x0 writes never forward.
    drive_d(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    drive_d(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    tick();
    push_exp(0, F_RWM, 1, "fw_x0_RegWriteM");
    push_exp(0, F_FWA, 0, "fw_x0_A");
    push_exp(0, F_FWB, 0, "fw_x0_B");
    drain(3);

    // Taken branch with a load-use match: flush wins, no stall.
    drive_d(1'b1, 1'b0, 1'b1, 3'd0, 5'd0, 5'd0, 5'd9);
    tick();
    drive_d(1'b0, 1'b1, 1'b0, 3'd0, 5'd1, 5'd9, 5'd0);
    bus.PCSrcE = 1'b1;
    push_exp(0, F_FLD, 1, "br_FlushD");
    push_exp(0, F_FLE, 1, "br_FlushE");
    push_exp(0, F_STF, 0, "br_StallF");
    push_exp(0, F_STD, 0, "br_StallD");
    tick();
    bus.PCSrcE = 1'b0;
    nop_d();
    push_exp(0, F_RWE,  0, "br_RegWriteE");
    push_exp(0, F_MWE,  0, "br_MemWriteE");
    push_exp(0, F_RSE,  0, "br_ResultSrcE");
    push_exp(0, F_FLD,  0, "br_FlushD_off");
    push_exp(0, F_FCNT, 1, "br_flush_cnt");
    push_exp(0, F_SCNT, 1, "br_stall_cnt");
    drain(3);

    // Saturation: a self-dependent load stalls every other cycle.
    drive_d(1'b1, 1'b0, 1'b1, 3'd0, 5'd5, 5'd0, 5'd5);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 26) push_exp(0, F_SCNT, 14, "sat_stall_cnt_14");
    end
    push_exp(0, F_SCNT, 15, "sat_stall_cnt_15");
    push_exp(0, F_FCNT, 1,  "sat_flush_cnt");
    drain(3);

    // Asynchronous reset with a full pipeline.
    drive_d(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd3);
    tick();
    tick();
    tick();
    push_exp(0, F_RWW, 1, "ar_full_RegWriteW");
    tick();
    rst = 1'b0;
    push_exp(0, F_RWE,  0, "ar_RegWriteE");
    push_exp(0, F_RWM,  0, "ar_RegWriteM");
    push_exp(0, F_RWW,  0, "ar_RegWriteW");
    push_exp(0, F_RDW,  0, "ar_RdW");
    push_exp(0, F_SCNT, 0, "ar_stall_cnt");
    push_exp(0, F_FCNT, 0, "ar_flush_cnt");
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    push_exp(0, F_RWE, 1, "ar_post_RegWriteE");
    push_exp(0, F_RDE, 3, "ar_post_RdE");
    push_exp(0, F_RWM, 0, "ar_post_RegWriteM");
    drain(3);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
